// File: rtl/key_word_assembler_pkg.sv
// key_word_assembler_pkg: shared state encoding for the key word assembler
package key_word_assembler_pkg;
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
endpackage

// File: rtl/key_word_assembler_idle_timer.sv
// idle_timer: counts idle cycles of a partial word; expired when the count saturates at all-ones
module idle_timer #(
   parameter int TIMEOUT_BITS = 24
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [TIMEOUT_BITS-1:0] count;
   // clear wins over enable; the owner leaves COLLECT before the count can wrap
   always_ff @(posedge sysclk or posedge reset)
      if (reset) count <= '0;
      else if (clear) count <= '0;
      else if (enable) count <= count + 1'b1;
   assign expired = &count;
endmodule

// File: rtl/key_word_assembler.sv
// key_word_assembler: shifts debounced 0/1 key pulses into a word and hands it off via valid/ready
module key_word_assembler
   import key_word_assembler_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int TIMEOUT_BITS = 24,
   parameter bit MSB_FIRST    = 1
) (
   input  logic                       sysclk,
   input  logic                       reset,
   input  logic                       bit0_pulse,
   input  logic                       bit1_pulse,
   input  logic                       word_ready,
   output logic [WIDTH-1:0]           word_data,
   output logic                       word_valid,
   output logic [$clog2(WIDTH+1)-1:0] bit_count,
   output logic                       busy,
   output logic                       overrun,
   output logic                       abort
);
   localparam int CW = $clog2(WIDTH+1);
   logic [1:0]       state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             acc, take, expired;
   logic [WIDTH-1:0] shifted, fresh;
   // a key counts only when exactly one of the two pulses is present
   assign acc     = bit0_pulse ^ bit1_pulse;
   assign take    = acc && (state != HOLD || word_ready);
   assign shifted = MSB_FIRST ? {sr[WIDTH-2:0], bit1_pulse} : {bit1_pulse, sr[WIDTH-1:1]};
   assign fresh   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit1_pulse} : {bit1_pulse, {(WIDTH-1){1'b0}}};
   // timer only runs while collecting; it sits at zero in IDLE and HOLD
   idle_timer #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_timer (
      .sysclk  (sysclk),
      .reset   (reset),
      .clear   (take || state != COLLECT),
      .enable  (state == COLLECT),
      .expired (expired)
   );
   // word assembly FSM; overrun and abort are single-cycle pulses
   always_ff @(posedge sysclk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         overrun <= 1'b0;
         abort   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         abort   <= 1'b0;
         case (state)
            IDLE:
               if (acc) begin
                  state <= COLLECT;
                  sr    <= fresh;
                  cnt   <= CW'(1);
               end
            COLLECT:
               if (acc) begin
                  sr  <= shifted;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH-1)) state <= HOLD;
               end else if (expired) begin
                  state <= IDLE;
                  sr    <= '0;
                  cnt   <= '0;
                  abort <= 1'b1;
               end
            HOLD:
               if (word_ready) begin
                  state <= acc ? COLLECT : IDLE;
                  sr    <= acc ? fresh : '0;
                  cnt   <= acc ? CW'(1) : '0;
               end else if (acc) overrun <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   assign word_data  = sr;
   assign bit_count  = cnt;
   assign word_valid = (state == HOLD);
   assign busy       = (state != IDLE);
endmodule

// File: tb/tb_key_word_assembler.sv
// tb_key_word_assembler: table-driven check of two assembler instances (MSB-first and LSB-first)
module tb_key_word_assembler;
   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       bit0_pulse = 1'b0, bit1_pulse = 1'b0, word_ready = 1'b0;
   logic [7:0] data_a, data_b;
   logic [3:0] cnt_a, cnt_b;
   logic       valid_a, busy_a, ovr_a, abt_a;
   logic       valid_b, busy_b, ovr_b, abt_b;
   int         tests = 0, fails = 0;

   always #5 sysclk = ~sysclk;

   key_word_assembler #(.WIDTH(8), .TIMEOUT_BITS(4), .MSB_FIRST(1)) dut_a (
      .sysclk(sysclk), .reset(reset), .bit0_pulse(bit0_pulse), .bit1_pulse(bit1_pulse),
      .word_ready(word_ready), .word_data(data_a), .word_valid(valid_a), .bit_count(cnt_a),
      .busy(busy_a), .overrun(ovr_a), .abort(abt_a));

   key_word_assembler #(.WIDTH(8), .TIMEOUT_BITS(4), .MSB_FIRST(0)) dut_b (
      .sysclk(sysclk), .reset(reset), .bit0_pulse(bit0_pulse), .bit1_pulse(bit1_pulse),
      .word_ready(word_ready), .word_data(data_b), .word_valid(valid_b), .bit_count(cnt_b),
      .busy(busy_b), .overrun(ovr_b), .abort(abt_b));

   typedef struct {
      logic       b0, b1, rdy;
      logic       v;
      logic [7:0] da, db;
      logic [3:0] cnt;
      logic       bsy, ov, ab;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic b0, b1, rdy, v, input logic [7:0] da, db,
                      input logic [3:0] cnt, input logic bsy, ov, ab);
      vec_t e;
      e.b0 = b0; e.b1 = b1; e.rdy = rdy; e.v = v; e.da = da; e.db = db;
      e.cnt = cnt; e.bsy = bsy; e.ov = ov; e.ab = ab;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input vec_t e);
      chk({tag, " valid_a"}, 8'(valid_a), 8'(e.v));
      chk({tag, " data_a"},  data_a,      e.da);
      chk({tag, " cnt_a"},   8'(cnt_a),   8'(e.cnt));
      chk({tag, " busy_a"},  8'(busy_a),  8'(e.bsy));
      chk({tag, " ovr_a"},   8'(ovr_a),   8'(e.ov));
      chk({tag, " abort_a"}, 8'(abt_a),   8'(e.ab));
      chk({tag, " data_b"},  data_b,      e.db);
      chk({tag, " valid_b"}, 8'(valid_b), 8'(e.v));
      chk({tag, " cnt_b"},   8'(cnt_b),   8'(e.cnt));
      chk({tag, " busy_b"},  8'(busy_b),  8'(e.bsy));
      chk({tag, " ovr_b"},   8'(ovr_b),   8'(e.ov));
      chk({tag, " abort_b"}, 8'(abt_b),   8'(e.ab));
   endtask

   task automatic apply(input string tag, input vec_t e);
      @(negedge sysclk);
      bit0_pulse = e.b0;
      bit1_pulse = e.b1;
      word_ready = e.rdy;
      @(posedge sysclk);
      #1;
      check_all(tag, e);
   endtask

   initial begin
      logic       keys [8];
      logic [7:0] ea [8];
      logic [7:0] eb [8];
      vec_t       z;
      keys = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ea   = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
      eb   = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h9A, 8'h4D};
      // quiet after reset release
      for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      // first word, keys spaced 3 cycles, downstream not ready
      for (int k = 0; k < 8; k++) begin
         add(!keys[k], keys[k], 0, k == 7, ea[k], eb[k], 4'(k + 1), 1, 0, 0);
         for (int j = 0; j < 2; j++) add(0, 0, 0, k == 7, ea[k], eb[k], 4'(k + 1), 1, 0, 0);
      end
      // key while held and not ready: overrun pulse, word frozen
      add(0, 1, 0, 1, 8'hB2, 8'h4D, 8, 1, 1, 0);
      add(0, 0, 0, 1, 8'hB2, 8'h4D, 8, 1, 0, 0);
      // a held key with both pulses is ignored, no overrun
      add(1, 1, 0, 1, 8'hB2, 8'h4D, 8, 1, 0, 0);
      // plain transfer
      add(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      // second word back to back, then transfer with a key on the same edge
      for (int k = 0; k < 8; k++) add(!keys[k], keys[k], 0, k == 7, ea[k], eb[k], 4'(k + 1), 1, 0, 0);
      add(0, 1, 1, 0, 8'h01, 8'h80, 1, 1, 0, 0);
      add(1, 0, 0, 0, 8'h02, 8'h40, 2, 1, 0, 0);
      add(0, 1, 0, 0, 8'h05, 8'hA0, 3, 1, 0, 0);
      // 15 idle cycles stay inside the timeout window
      for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 8'h05, 8'hA0, 3, 1, 0, 0);
      add(0, 1, 0, 0, 8'h0B, 8'hD0, 4, 1, 0, 0);
      // 16 idle cycles abort the partial word
      for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 8'h0B, 8'hD0, 4, 1, 0, 0);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      // fresh 3-bit partial word, then abort
      add(0, 1, 0, 0, 8'h01, 8'h80, 1, 1, 0, 0);
      add(0, 1, 0, 0, 8'h03, 8'hC0, 2, 1, 0, 0);
      add(1, 0, 0, 0, 8'h06, 8'h60, 3, 1, 0, 0);
      for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 8'h06, 8'h60, 3, 1, 0, 0);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
      add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      // both keys together in COLLECT are ignored
      add(0, 1, 0, 0, 8'h01, 8'h80, 1, 1, 0, 0);
      add(1, 0, 0, 0, 8'h02, 8'h40, 2, 1, 0, 0);
      add(1, 1, 0, 0, 8'h02, 8'h40, 2, 1, 0, 0);
      add(0, 1, 0, 0, 8'h05, 8'hA0, 3, 1, 0, 0);
      add(0, 1, 0, 0, 8'h0B, 8'hD0, 4, 1, 0, 0);
      add(0, 1, 0, 0, 8'h17, 8'hE8, 5, 1, 0, 0);

      repeat (2) @(negedge sysclk);
      reset = 1'b0;
      for (int i = 0; i < tbl.size(); i++) apply($sformatf("v%0d", i), tbl[i]);

      // asynchronous reset mid-word: outputs clear before any clock edge
      z = '{b0: 0, b1: 0, rdy: 0, v: 0, da: 8'h00, db: 8'h00, cnt: 0, bsy: 0, ov: 0, ab: 0};
      bit0_pulse = 1'b0;
      bit1_pulse = 1'b0;
      #1 reset = 1'b1;
      #1 check_all("async_reset", z);
      @(negedge sysclk);
      reset = 1'b0;
      z.b1 = 1; z.da = 8'h01; z.db = 8'h80; z.cnt = 1; z.bsy = 1;
      apply("post_reset", z);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
